os_psum_drain: RTL and testbench

Output-stationary psum drain stage. It sits directly downstream of the systolic array and consumes the column-skewed partial sums that the array shifts out under the per-column `shift_psum` enables. It de-skews the columns into full output rows, optionally applies ReLU, and writes each row as one wide word to the psum SRAM through a ready/enable handshake with an auto-incrementing address. It signals completion of each drained tile.

---
 rtl/os_psum_drain.sv | 203 ++++++++++++++++++++
 tb/tb_os_psum_drain.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/os_psum_drain.sv
// rtl/os_psum_drain.sv - output-stationary psum drain: column de-skew, optional ReLU, SRAM row writer
// Optional feature macro: OS_PSUM_DRAIN_RELU_EN (clamp negative psum fields to zero when the output word is loaded)
module os_psum_drain #(
  parameter int psum_bw    = 16,
  parameter int col        = 8,
  parameter int row        = 8,
  parameter int addr_width = 8,
  parameter int fifo_depth = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] array_psum_i,
  input  logic [col-1:0]         array_psum_valid_i,
  input  logic                   sram_wr_ready_i,
  output logic                   sram_wr_en_o,
  output logic [addr_width-1:0]  sram_addr_o,
  output logic [psum_bw*col-1:0] sram_wdata_o,
  output logic                   tile_done_o,
  output logic                   busy_o,
  output logic                   overflow_o
);

  localparam int ptr_w = $clog2(fifo_depth);
  localparam int cnt_w = (row > 1) ? $clog2(row) : 1;

  localparam logic [ptr_w:0]        ptr_one   = (ptr_w + 1)'(1);
  localparam logic [cnt_w-1:0]      wcnt_one  = cnt_w'(1);
  localparam logic [cnt_w-1:0]      wcnt_last = cnt_w'(row - 1);
  localparam logic [addr_width-1:0] addr_one  = addr_width'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Per-column de-skew FIFOs; pointers carry one extra wrap bit to tell full from empty
  logic [psum_bw-1:0] mem_q    [col][fifo_depth];
  logic [psum_bw-1:0] mem_d    [col][fifo_depth];
  logic [ptr_w:0]     wr_ptr_q [col];
  logic [ptr_w:0]     wr_ptr_d [col];
  logic [ptr_w:0]     rd_ptr_q [col];
  logic [ptr_w:0]     rd_ptr_d [col];

  logic [col-1:0]     fifo_empty;
  logic [col-1:0]     fifo_full;
  logic [col-1:0]     push_en;
  logic               ovf_hit;

  // Output register, address/write counters and control
  logic                   sram_wr_en_q, sram_wr_en_d;
  logic [addr_width-1:0]  sram_addr_q, sram_addr_d;
  logic [psum_bw*col-1:0] sram_wdata_q, sram_wdata_d;
  logic [cnt_w-1:0]       wcnt_q, wcnt_d;
  logic                   tile_done_q, tile_done_d;
  logic                   overflow_q, overflow_d;
  state_t                 state_q, state_d;

  logic                   commit;
  logic                   pop;
  logic                   tile_last;
  logic [psum_bw*col-1:0] head_word;

  assign commit    = sram_wr_en_q && sram_wr_ready_i;
  assign pop       = (~|fifo_empty) && (!sram_wr_en_q || commit);
  assign tile_last = commit && (wcnt_q == wcnt_last);

  assign sram_wr_en_o = sram_wr_en_q;
  assign sram_addr_o  = sram_addr_q;
  assign sram_wdata_o = sram_wdata_q;
  assign tile_done_o  = tile_done_q;
  assign overflow_o   = overflow_q;
  assign busy_o       = (~&fifo_empty) || sram_wr_en_q;

  // FIFO occupancy flags from the pointer pairs
  always_comb begin
    fifo_empty = '0;
    fifo_full  = '0;
    for (int c = 0; c < col; c++) begin
      fifo_empty[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
      fifo_full[c]  = (wr_ptr_q[c][ptr_w] != rd_ptr_q[c][ptr_w]) &&
                      (wr_ptr_q[c][ptr_w-1:0] == rd_ptr_q[c][ptr_w-1:0]);
    end
  end

  // Assemble the row sitting at the FIFO heads, clamping negative fields when ReLU is built in
  always_comb begin
    head_word = '0;
    for (int c = 0; c < col; c++) begin
      head_word[psum_bw*c +: psum_bw] = mem_q[c][rd_ptr_q[c][ptr_w-1:0]];
`ifdef OS_PSUM_DRAIN_RELU_EN
      if (mem_q[c][rd_ptr_q[c][ptr_w-1:0]][psum_bw-1]) begin
        head_word[psum_bw*c +: psum_bw] = '0;
      end
`endif
    end
  end

  // FIFO push/pop; a push into a full FIFO survives only if that FIFO pops in the same cycle
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    push_en  = '0;
    ovf_hit  = 1'b0;
    for (int c = 0; c < col; c++) begin
      push_en[c] = array_psum_valid_i[c] && (!fifo_full[c] || pop);
      if (array_psum_valid_i[c] && fifo_full[c] && !pop) begin
        ovf_hit = 1'b1;
      end
      if (push_en[c]) begin
        mem_d[c][wr_ptr_q[c][ptr_w-1:0]] = array_psum_i[psum_bw*c +: psum_bw];
        wr_ptr_d[c] = wr_ptr_q[c] + ptr_one;
      end
      if (pop) begin
        rd_ptr_d[c] = rd_ptr_q[c] + ptr_one;
      end
    end
  end

  // Output register, address/write counters and tile FSM next-state
  always_comb begin
    sram_wr_en_d = sram_wr_en_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    wcnt_d       = wcnt_q;
    overflow_d   = overflow_q || ovf_hit;
    state_d      = state_q;

    if (commit) begin
      sram_wr_en_d = 1'b0;
      sram_addr_d  = sram_addr_q + addr_one;
      wcnt_d       = tile_last ? '0 : (wcnt_q + wcnt_one);
    end
    // A pop refills the output register in the same cycle the previous word commits
    if (pop) begin
      sram_wr_en_d = 1'b1;
      sram_wdata_d = head_word;
    end

    case (state_q)
      ST_IDLE: begin
        if (|array_psum_valid_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (tile_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (tile_last) begin
          state_d = ST_DONE;
        end else if (busy_o || (|array_psum_valid_i)) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    tile_done_d = (state_d == ST_DONE) && tile_last;
  end

  // FIFO storage carries no reset; the pointers alone define its contents
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // All control and output state, flushed by the synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < col; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
      sram_wr_en_q <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      wcnt_q       <= '0;
      tile_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
      state_q      <= ST_IDLE;
    end else begin
      for (int c = 0; c < col; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
      end
      sram_wr_en_q <= sram_wr_en_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      wcnt_q       <= wcnt_d;
      tile_done_q  <= tile_done_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
    end
  end

endmodule

// File: tb/tb_os_psum_drain.sv
// tb/tb_os_psum_drain.sv - self-checking bench for os_psum_drain
module tb_os_psum_drain;

  localparam int PB = 16;
  localparam int NC = 8;
  localparam int NR = 8;
  localparam int AW = 8;
  localparam int FD = 8;
  localparam int WW = PB * NC;
  localparam int QD = 4096;

  typedef struct {
    logic [WW-1:0] din;
    logic [WW-1:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [WW-1:0] array_psum_i = '0;
  logic [NC-1:0] array_psum_valid_i = '0;
  logic          sram_wr_ready_i = 1'b1;
  logic          sram_wr_en_o;
  logic [AW-1:0] sram_addr_o;
  logic [WW-1:0] sram_wdata_o;
  logic          tile_done_o;
  logic          busy_o;
  logic          overflow_o;

  always #5 clk = ~clk;

  os_psum_drain dut (
    .clk                (clk),
    .reset              (reset),
    .array_psum_i       (array_psum_i),
    .array_psum_valid_i (array_psum_valid_i),
    .sram_wr_ready_i    (sram_wr_ready_i),
    .sram_wr_en_o       (sram_wr_en_o),
    .sram_addr_o        (sram_addr_o),
    .sram_wdata_o       (sram_wdata_o),
    .tile_done_o        (tile_done_o),
    .busy_o             (busy_o),
    .overflow_o         (overflow_o)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: per-column psum lists; row k is the k-th psum of every column
  logic [PB-1:0] colbuf [NC][QD];
  int            col_wp [NC];
  int            col_rp [NC];
  logic [WW-1:0] exp_rows [$];
  logic [AW-1:0] exp_addr = '0;
  int            tile_cnt = 0;
  int            tile_pulses = 0;
  int            total_commits = 0;
  logic [AW-1:0] addr_256 = '1;
  logic          td_exp = 1'b0;
  logic          mon_en = 1'b0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [WW-1:0] prev_data = '0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chka(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] relu_word(input logic [WW-1:0] w);
    logic [WW-1:0] r;
    r = w;
`ifdef OS_PSUM_DRAIN_RELU_EN
    for (int c = 0; c < NC; c++) begin
      if ($signed(w[PB*c +: PB]) < 0) r[PB*c +: PB] = '0;
    end
`endif
    return r;
  endfunction

  function automatic void model_push(input logic [NC-1:0] m, input logic [WW-1:0] b);
    logic [WW-1:0] w;
    bit all_have;
    for (int c = 0; c < NC; c++) begin
      if (m[c]) begin
        colbuf[c][col_wp[c] % QD] = b[PB*c +: PB];
        col_wp[c]++;
      end
    end
    all_have = 1'b1;
    while (all_have) begin
      for (int c = 0; c < NC; c++) begin
        if (col_wp[c] == col_rp[c]) all_have = 1'b0;
      end
      if (all_have) begin
        w = '0;
        for (int c = 0; c < NC; c++) begin
          w[PB*c +: PB] = colbuf[c][col_rp[c] % QD];
          col_rp[c]++;
        end
        exp_rows.push_back(relu_word(w));
      end
    end
  endfunction

  // Write monitor: sampled on the falling edge, between active edges
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      chk1("tile_done", tile_done_o, td_exp);
      if (tile_done_o) tile_pulses++;
      td_exp = 1'b0;
      if (prev_stall) begin
        chk1("stall_wr_en", sram_wr_en_o, 1'b1);
        chka("stall_addr", sram_addr_o, prev_addr);
        chkw("stall_data", sram_wdata_o, prev_data);
      end
      if (sram_wr_en_o && sram_wr_ready_i) begin
        chka("wr_addr", sram_addr_o, exp_addr);
        if (exp_rows.size() == 0) begin
          chki("unexpected_write", 1, 0);
        end else begin
          chkw("wr_data", sram_wdata_o, exp_rows.pop_front());
        end
        if (total_commits == 256) addr_256 = sram_addr_o;
        total_commits++;
        exp_addr = exp_addr + 8'd1;
        tile_cnt++;
        if (tile_cnt == NR) begin
          tile_cnt = 0;
          td_exp = 1'b1;
        end
      end
      prev_stall = sram_wr_en_o && !sram_wr_ready_i;
      prev_addr  = sram_addr_o;
      prev_data  = sram_wdata_o;
    end else begin
      td_exp = 1'b0;
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NC-1:0] m, input logic [WW-1:0] b);
    array_psum_valid_i = m;
    array_psum_i = b;
    model_push(m, b);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    array_psum_valid_i = '0;
    array_psum_i = '0;
    sram_wr_ready_i = 1'b1;
    for (int c = 0; c < NC; c++) begin
      col_wp[c] = 0;
      col_rp[c] = 0;
    end
    exp_rows.delete();
    exp_addr = '0;
    tile_cnt = 0;
    tile_pulses = 0;
    total_commits = 0;
    addr_256 = '1;
    tick();
    reset = 1'b0;
    chk1("rst_wr_en", sram_wr_en_o, 1'b0);
    chka("rst_addr", sram_addr_o, '0);
    chkw("rst_wdata", sram_wdata_o, '0);
    chk1("rst_tile_done", tile_done_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_overflow", overflow_o, 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    array_psum_valid_i = '0;
    sram_wr_ready_i = 1'b1;
    while ((busy_o || exp_rows.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    chki("drain_in_budget", (n < 300) ? 1 : 0, 1);
    chk1("busy_after_drain", busy_o, 1'b0);
    tick();
    tick();
  endtask

  // Column c valid over cycles c..c+NR-1 carrying base+16*c+k; ready low over [st0,st1)
  task automatic skew_pass(input int base, input int st0, input int st1, input bit lat);
    for (int t = 0; t < NC + NR - 1; t++) begin
      logic [NC-1:0] m;
      logic [WW-1:0] b;
      m = '0;
      b = '0;
      for (int c = 0; c < NC; c++) begin
        if (t >= c && t < c + NR) begin
          m[c] = 1'b1;
          b[PB*c +: PB] = PB'(base + 16 * c + (t - c));
        end
      end
      sram_wr_ready_i = !(t >= st0 && t < st1);
      drive(m, b);
      if (lat && t == NC - 1) chk1("latency_not_yet", sram_wr_en_o, 1'b0);
      if (lat && t == NC) chk1("latency_first_write", sram_wr_en_o, 1'b1);
    end
    array_psum_valid_i = '0;
    sram_wr_ready_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    logic [WW-1:0] w;
    logic [PB-1:0] f2_exp;
    int g;

    for (int i = 0; i < 8; i++) begin
      w = '0;
      case (i)
        0: w[PB*2 +: PB] = 16'hFFF0;
        1: for (int c = 0; c < NC; c++) w[PB*c +: PB] = 16'h7FFF;
        2: for (int c = 0; c < NC; c++) w[PB*c +: PB] = 16'h8000;
        3: for (int c = 0; c < NC; c++) w[PB*c +: PB] = (c % 2 == 0) ? 16'h0001 : 16'hFFFF;
        default: w = {$urandom, $urandom, $urandom, $urandom};
      endcase
      vecs[i].din = w;
      vecs[i].exp = relu_word(w);
    end
`ifdef OS_PSUM_DRAIN_RELU_EN
    f2_exp = 16'h0000;
`else
    f2_exp = 16'hFFF0;
`endif

    do_reset();
    mon_en = 1'b1;

    // Skewed pass with the latency check
    skew_pass(0, -1, -1, 1'b1);
    wait_idle();
    chki("pass1_commits", total_commits, 8);
    chki("pass1_tile_pulses", tile_pulses, 1);
    chka("pass1_next_addr", sram_addr_o, 8'd8);

    // Back-pressure for 5 cycles mid-tile
    skew_pass(100, 10, 15, 1'b0);
    wait_idle();
    chki("bp_commits", total_commits, 16);
    chki("bp_tile_pulses", tile_pulses, 2);
    chka("bp_next_addr", sram_addr_o, 8'd16);
    chk1("bp_no_overflow", overflow_o, 1'b0);

    // Table-driven ReLU / pass-through vectors, one row each
    for (int i = 0; i < 8; i++) begin
      drive('1, vecs[i].din);
      drive('0, '0);
      chk1("vec_wr_en", sram_wr_en_o, 1'b1);
      chkw("vec_wdata", sram_wdata_o, vecs[i].exp);
      if (i == 0) begin
        w = sram_wdata_o;
        n_cmp++;
        if (w[PB*2 +: PB] !== f2_exp) begin
          n_fail++;
          $display("FAIL relu_field2: got %h expected %h", w[PB*2 +: PB], f2_exp);
        end
      end
    end
    wait_idle();
    chki("vec_tile_pulses", tile_pulses, 3);

    // Reset mid-tile after 3 writes, then a fresh pass from address 0
    skew_pass(200, 0, NC + NR - 1, 1'b0);
    g = 0;
    while (tile_cnt < 3 && g < 20) begin
      tick();
      g++;
    end
    chki("mid_tile_writes", tile_cnt, 3);
    do_reset();
    tick();
    chk1("no_write_after_reset", sram_wr_en_o, 1'b0);
    skew_pass(300, -1, -1, 1'b1);
    wait_idle();
    chki("after_reset_commits", total_commits, 8);
    chki("after_reset_pulses", tile_pulses, 1);
    chka("after_reset_addr", sram_addr_o, 8'd8);

    // Full FIFO: push with simultaneous pop is legal
    do_reset();
    sram_wr_ready_i = 1'b0;
    for (int k = 0; k < 9; k++) begin
      w = '0;
      for (int c = 0; c < NC; c++) w[PB*c +: PB] = PB'(400 + 16 * k + c);
      drive('1, w);
    end
    chk1("full_no_overflow", overflow_o, 1'b0);
    sram_wr_ready_i = 1'b1;
    w = '0;
    for (int c = 0; c < NC; c++) w[PB*c +: PB] = PB'(600 + c);
    drive('1, w);
    chk1("full_push_pop_no_overflow", overflow_o, 1'b0);
    wait_idle();
    chki("full_commits", total_commits, 10);
    chki("full_pulses", tile_pulses, 1);

    // Overflow: 10 pushes into column 0 with the SRAM stalled
    do_reset();
    sram_wr_ready_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(8'h01, WW'(k + 1));
      if (k == 7) chk1("ovf_at_full_not_set", overflow_o, 1'b0);
    end
    drive('0, '0);
    chk1("ovf_set", overflow_o, 1'b1);
    chk1("ovf_busy", busy_o, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    chk1("ovf_sticky", overflow_o, 1'b1);
    chk1("ovf_no_write", sram_wr_en_o, 1'b0);

    // Address wrap over 33 tiles
    do_reset();
    for (int i = 0; i < 33 * NR; i++) begin
      drive('1, {$urandom, $urandom, $urandom, $urandom});
    end
    wait_idle();
    chki("wrap_commits", total_commits, 264);
    chki("wrap_tile_pulses", tile_pulses, 33);
    chka("wrap_addr_257th", addr_256, 8'd0);
    chka("wrap_next_addr", sram_addr_o, 8'd8);

    // Randomized valids and back-pressure against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [NC-1:0] m;
      m = '0;
      for (int c = 0; c < NC; c++) begin
        if (($urandom % 2) == 1 && (col_wp[c] - total_commits) < FD) m[c] = 1'b1;
      end
      sram_wr_ready_i = (($urandom % 4) != 0);
      drive(m, {$urandom, $urandom, $urandom, $urandom});
    end
    sram_wr_ready_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      int mx;
      logic [NC-1:0] m;
      mx = 0;
      m = '0;
      for (int c = 0; c < NC; c++) if (col_wp[c] > mx) mx = col_wp[c];
      for (int c = 0; c < NC; c++) begin
        if (col_wp[c] < mx && (col_wp[c] - total_commits) < FD) m[c] = 1'b1;
      end
      if (mx == col_wp[0] && mx == col_wp[1] && mx == col_wp[2] && mx == col_wp[3] &&
          mx == col_wp[4] && mx == col_wp[5] && mx == col_wp[6] && mx == col_wp[7]) break;
      drive(m, {$urandom, $urandom, $urandom, $urandom});
    end
    wait_idle();
    chki("rand_rows_left", exp_rows.size(), 0);
    chki("rand_commits", total_commits, col_wp[0]);
    chki("rand_tile_pulses", tile_pulses, total_commits / NR);
    chk1("rand_no_overflow", overflow_o, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
